// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous memory between the CPU (port A) and a
//   debug/loader master (port B). One access is in flight at a time; requests
//   are sampled only while idle. A simultaneous request goes to the port that
//   was not served last (round-robin). The grant pulses for one cycle, and a
//   read returns data on that port's rvalid pulse two edges after the grant.
//
//   Build option:
//     MEM_ARB_FIXED_PRIO_EN  defined   -> port A always wins a simultaneous
//                                          request (B may starve)
//                            undefined -> round-robin (default)
//
//   Ports:
//     clk, rst_n                 divided clock, asynchronous active-low reset
//     a_req/a_we/a_addr/a_data   port A request (held until a_gnt)
//     a_gnt, a_rvalid, a_rdata   port A grant pulse, read-data pulse, read data
//     b_*                        same set for port B
//     mem_we/mem_addr/mem_data   memory control, driven by the arbiter
//     mem_out                    memory read data (one cycle after address)
//     busy                       an access is in flight
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_t;

  state_t                r_state;
  owner_t                r_owner;
  owner_t                r_last_owner;
  logic                  r_a_gnt;
  logic                  r_b_gnt;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;

  logic                  w_any_req;
  logic                  w_win_b;

  // Winner selection, only consulted while idle.
  always_comb begin
    w_any_req = a_req | b_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
    w_win_b   = b_req & ~a_req;
`else
    // B wins when alone, or on a tie when A was served last.
    w_win_b   = b_req & (~a_req | (r_last_owner == OWN_A));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_A;
      r_last_owner <= OWN_B;
      r_a_gnt      <= 1'b0;
      r_b_gnt      <= 1'b0;
      r_a_rvalid   <= 1'b0;
      r_b_rvalid   <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      // Grant and rvalid are single-cycle pulses.
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            if (w_win_b) begin
              r_b_gnt      <= 1'b1;
              r_mem_we     <= b_we;
              r_mem_addr   <= b_addr;
              r_mem_data   <= b_data;
              r_owner      <= OWN_B;
              r_last_owner <= OWN_B;
            end else begin
              r_a_gnt      <= 1'b1;
              r_mem_we     <= a_we;
              r_mem_addr   <= a_addr;
              r_mem_data   <= a_data;
              r_owner      <= OWN_A;
              r_last_owner <= OWN_A;
            end
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // The memory samples mem_* at this edge; mem_we still tells us
          // whether the access in flight is a write.
          r_mem_we <= 1'b0;
          r_state  <= r_mem_we ? S_IDLE : S_RESP;
        end

        S_RESP: begin
          if (r_owner == OWN_B) begin
            r_b_rdata  <= mem_out;
            r_b_rvalid <= 1'b1;
          end else begin
            r_a_rdata  <= mem_out;
            r_a_rvalid <= 1'b1;
          end
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_gnt    = r_a_gnt;
  assign b_gnt    = r_b_gnt;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// traffic (with occasional resets), all checked against a transaction-level
// model of grant timing, memory contents and read latency.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;
  logic          busy;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out), .busy(busy)
  );

  // Single-port synchronous memory (read-first), cleared at start of run.
  logic [DW-1:0] ram [64];
  logic          ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_data;
    end
    mem_out <= ram[mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mdl_mem [64];
  int            t;          // count of active (non-reset) edges
  int            next_free;  // first edge at which a request may be sampled
  int            rv_at;      // edge at which read data is returned
  logic          rv_b;
  logic [DW-1:0] rv_data;
  int            wr_at;      // edge at which a granted write lands
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          last_b;

  logic          e_a_gnt, e_b_gnt, e_a_rv, e_b_rv, e_we, e_busy;
  logic [DW-1:0] e_a_rd, e_b_rd, e_data;
  logic [AW-1:0] e_addr;

  task automatic model_reset();
    next_free = 0; rv_at = -1; wr_at = -1; last_b = 1'b1;
    e_a_gnt = 0; e_b_gnt = 0; e_a_rv = 0; e_b_rv = 0; e_we = 0; e_busy = 0;
    e_a_rd = '0; e_b_rd = '0; e_data = '0; e_addr = '0;
  endtask

  task automatic model_edge();
    logic win_b, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] da;
    e_a_gnt = 0; e_b_gnt = 0; e_a_rv = 0; e_b_rv = 0; e_we = 0;
    if (wr_at == t) mdl_mem[wr_addr] = wr_data;
    if (rv_at == t) begin
      if (rv_b) begin e_b_rv = 1; e_b_rd = rv_data; end
      else      begin e_a_rv = 1; e_a_rd = rv_data; end
    end
    if (t >= next_free && (a_req || b_req)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win_b = b_req && !a_req;
`else
      win_b = b_req && (!a_req || !last_b);
`endif
      we = win_b ? b_we : a_we;
      ad = win_b ? b_addr : a_addr;
      da = win_b ? b_data : a_data;
      if (win_b) e_b_gnt = 1; else e_a_gnt = 1;
      e_we = we; e_addr = ad; e_data = da; last_b = win_b;
      if (we) begin
        wr_at = t + 1; wr_addr = ad; wr_data = da; next_free = t + 2;
      end else begin
        rv_at = t + 2; rv_b = win_b; rv_data = mdl_mem[ad]; next_free = t + 3;
      end
    end
    e_busy = (t + 1 < next_free);
    t++;
  endtask

  task automatic compare_all();
    check_val("a_gnt", a_gnt, e_a_gnt);
    check_val("b_gnt", b_gnt, e_b_gnt);
    check_val("a_rvalid", a_rvalid, e_a_rv);
    check_val("b_rvalid", b_rvalid, e_b_rv);
    check_val("a_rdata", a_rdata, e_a_rd);
    check_val("b_rdata", b_rdata, e_b_rd);
    check_val("mem_we", mem_we, e_we);
    check_val("mem_addr", mem_addr, e_addr);
    check_val("mem_data", mem_data, e_data);
    check_val("busy", busy, e_busy);
  endtask

  // ---------------- stimulus ----------------
  logic a_act, b_act;

  // Called at a negedge; returns at the next negedge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  // mode 0: directed, 1: random traffic, 2: re-request immediately
  task automatic tick(input int mode);
    if (a_act && e_a_gnt) a_act = 1'b0;
    if (b_act && e_b_gnt) b_act = 1'b0;
    if (mode != 0) begin
      if (!a_act && (mode == 2 || $urandom_range(0, 2) == 0)) begin
        a_act = 1; a_we = 1'($urandom); a_addr = rand_addr(); a_data = DW'($urandom);
      end else if (!a_act) begin
        a_we = 1'($urandom); a_addr = AW'($urandom); a_data = DW'($urandom);
      end
      if (!b_act && (mode == 2 || $urandom_range(0, 2) == 0)) begin
        b_act = 1; b_we = 1'($urandom); b_addr = rand_addr(); b_data = DW'($urandom);
      end else if (!b_act) begin
        b_we = 1'($urandom); b_addr = AW'($urandom); b_data = DW'($urandom);
      end
    end
    a_req = a_act;
    b_req = b_act;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!a_act && !b_act && t >= next_free && rv_at < t) break;
      tick(0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_act = 0; b_act = 0; a_req = 0; b_req = 0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    step();
    rst_n = 1'b1;
  endtask

  int ga, gb;

  initial begin
    rst_n = 1'b0; ram_clr = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_data = '0; a_act = 0;
    b_req = 0; b_we = 0; b_addr = '0; b_data = '0; b_act = 0;
    t = 0;
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    ram_clr = 1'b0;
    rst_n = 1'b1;

    // Single write then read on port A.
    a_act = 1; a_we = 1; a_addr = 6'h05; a_data = 16'h1234;
    tick(0);
    check_val("t1_wr_gnt", a_gnt, 1);
    check_val("t1_wr_we", mem_we, 1);
    tick(0);
    check_val("t1_we_drop", mem_we, 0);
    drain();
    a_act = 1; a_we = 0; a_addr = 6'h05; a_data = 16'h0;
    tick(0); tick(0); tick(0);
    check_val("t1_rvalid", a_rvalid, 1);
    check_val("t1_rdata", a_rdata, 16'h1234);
    drain();

    // Simultaneous requests right after reset.
    do_reset();
    a_act = 1; a_we = 0; a_addr = 6'h01;
    b_act = 1; b_we = 1; b_addr = 6'h02; b_data = 16'hBEEF;
    tick(0);
    check_val("sim_first_a", a_gnt, 1);
    tick(0);
    a_act = 1;
    tick(0); tick(0);
`ifdef MEM_ARB_FIXED_PRIO_EN
    check_val("sim_second_a", a_gnt, 1);
`else
    check_val("sim_second_b", b_gnt, 1);
`endif
    drain();

    // Continuous contention over 8 accesses.
    ga = 0; gb = 0;
    for (int i = 0; i < 60 && ga + gb < 8; i++) begin
      tick(2);
      ga += int'(a_gnt);
      gb += int'(b_gnt);
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    check_val("cont_a_count", ga, 8);
    check_val("cont_b_count", gb, 0);
`else
    check_val("cont_a_count", ga, 4);
    check_val("cont_b_count", gb, 4);
`endif
    drain();

    // Cross-port data: B writes, A reads.
    b_act = 1; b_we = 1; b_addr = 6'h3F; b_data = 16'hFFFF;
    drain();
    a_act = 1; a_we = 0; a_addr = 6'h3F;
    drain();
    check_val("xport_rdata", a_rdata, 16'hFFFF);

    // Address changes after grant do not affect the access in flight.
    a_act = 1; a_we = 0; a_addr = 6'h10;
    tick(0);
    check_val("chg_gnt", a_gnt, 1);
    a_addr = 6'h20;
    tick(0);
    check_val("chg_mem_addr", mem_addr, 6'h10);
    drain();

    // Reset while in RESP: no rvalid, A wins the next tie.
    a_act = 1; a_we = 0; a_addr = 6'h05;
    tick(0); tick(0);
    check_val("rst_busy_before", busy, 1);
    do_reset();
    step();
    a_act = 1; a_we = 0; a_addr = 6'h3F;
    b_act = 1; b_we = 0; b_addr = 6'h05;
    tick(0);
    check_val("rst_next_a", a_gnt, 1);
    check_val("rst_next_b", b_gnt, 0);
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick(1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
